data_memory_ws: RTL

Parametrised successor to the single-cycle data memory: word-organised, byte-lane-writable data RAM for the MEM stage of the ARM pipeline. It adds a programmable wait-state count and a ready handshake, so the hazard/freeze logic can stall the pipeline on slow accesses. Byte addresses are translated from a configurable base; out-of-range accesses are harmless.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 35 +++
 rtl/data_memory_ws.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: state encoding and lane/offset derivations shared by the data memory files.
package dmem_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   function automatic int lanes(input int w);
      return w / 8;
   endfunction

   function automatic int off_w(input int w);
      return $clog2(w / 8);
   endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W RAM, per-byte synchronous write, registered read port.
// The read register loads zero instead of RAM data when i_clr is set.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int IW     = 6
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_we,
   input  logic                       i_re,
   input  logic                       i_clr,
   input  logic [IW-1:0]              i_idx,
   input  logic [DATA_W-1:0]          i_din,
   input  logic [lanes(DATA_W)-1:0]   i_be,
   output logic [DATA_W-1:0]          o_q
);
   localparam int NL = lanes(DATA_W);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // RAM contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (i_we)
         for (int i = 0; i < NL; i++)
            if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_din[8*i +: 8];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) o_q <= '0;
      else if (i_re) o_q <= i_clr ? '0 : r_mem[i_idx];
   end
endmodule

// File: rtl/data_memory_ws.sv
// data_memory_ws: byte-lane data RAM with programmable wait states and a ready handshake.
// Define MEM_ALIGN_CHECK_EN to add alignErr and suppress misaligned accesses.
module data_memory_ws
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 3
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       readSig,
   input  logic                       writeSig,
   input  logic [ADDR_W-1:0]          address,
   input  logic [DATA_W-1:0]          dataIn,
   input  logic [lanes(DATA_W)-1:0]   byteEn,
   output logic [DATA_W-1:0]          dataOut,
   output logic                       ready
`ifdef MEM_ALIGN_CHECK_EN
   ,output logic                      alignErr
`endif
);
   localparam int NL = lanes(DATA_W);
   localparam int OW = off_w(DATA_W);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   logic [1:0]        r_state, w_next;
   logic [CW-1:0]     r_cnt, w_cnt;
   logic              r_wr, r_inr;
   logic [IW-1:0]     r_idx;
   logic [DATA_W-1:0] r_din;
   logic [NL-1:0]     r_be;
   logic              w_req, w_live, w_inr, w_commit, w_sup;
   logic              w_op_wr, w_op_inr;
   logic [IW-1:0]     w_idx, w_op_idx;
   logic [DATA_W-1:0] w_op_din;
   logic [NL-1:0]     w_op_be;
   logic [ADDR_W-1:0] w_diff, w_word;

   assign w_req  = readSig | writeSig;
   assign w_diff = address - ADDR_W'(BASE_ADDR);
   assign w_word = w_diff >> OW;
   assign w_inr  = (address >= ADDR_W'(BASE_ADDR)) && (w_word < ADDR_W'(DEPTH));
   assign w_idx  = w_word[IW-1:0];

   // With zero wait states the commit edge is the request edge, so use live inputs in IDLE
   assign w_live   = (r_state == S_IDLE);
   assign w_op_wr  = w_live ? writeSig : r_wr;
   assign w_op_inr = w_live ? w_inr    : r_inr;
   assign w_op_idx = w_live ? w_idx    : r_idx;
   assign w_op_din = w_live ? dataIn   : r_din;
   assign w_op_be  = w_live ? byteEn   : r_be;
   assign w_commit = (w_next == S_ACK);

`ifdef MEM_ALIGN_CHECK_EN
   logic r_mis, w_mis;
   assign w_mis = (address & ADDR_W'(NL - 1)) != '0;
   assign w_sup = w_live ? w_mis : r_mis;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_mis <= 1'b0;
      else if (w_live && w_req) r_mis <= w_mis;
   end
   always_comb alignErr = (r_state == S_ACK) & r_mis;
`else
   assign w_sup = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr  <= 1'b0;
         r_inr <= 1'b0;
         r_idx <= '0;
         r_din <= '0;
         r_be  <= '0;
      end else if (w_live && w_req) begin
         r_wr  <= writeSig;
         r_inr <= w_inr;
         r_idx <= w_idx;
         r_din <= dataIn;
         r_be  <= byteEn;
      end
   end

   always_comb begin
      w_next = (r_state == S_IDLE) ? (w_req ? ((WAIT_CYCLES == 0) ? S_ACK : S_WAIT) : S_IDLE) :
               (r_state == S_WAIT) ? ((r_cnt == '0) ? S_ACK : S_WAIT) : S_IDLE;
      w_cnt  = (w_live && w_req) ? CNT_INIT :
               (r_state == S_WAIT && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
   end

   always_comb ready = w_live ? ~w_req : (r_state == S_ACK);

   dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_array (
      .clk   (clk),
      .rst   (rst),
      .i_we  (w_commit & w_op_wr & w_op_inr & ~w_sup),
      .i_re  (w_commit & ~w_op_wr & ~w_sup),
      .i_clr (~w_op_inr),
      .i_idx (w_op_idx),
      .i_din (w_op_din),
      .i_be  (w_op_be),
      .o_q   (dataOut)
   );
endmodule
